// File: rtl/counter_read_latch.sv
// Read-back path of one timer channel: count latch, status latch and the
// LSB/MSB byte pointer that sequences CPU reads.
module counter_read_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] current_count,
    input  logic        out_level,
    input  logic        null_count,
    input  logic [1:0]  rw_mode,
    input  logic [2:0]  mode,
    input  logic        bcd,
    input  logic        ctrl_wr,
    input  logic        latch_cmd,
    input  logic        status_cmd,
    input  logic        rd,
    output logic [7:0]  rd_data,
    output logic        rd_ack,
    output logic        count_latched,
    output logic        status_latched
);

    typedef enum logic {
        LSB_NEXT = 1'b0,
        MSB_NEXT = 1'b1
    } ptr_t;

    ptr_t        r_ptr, w_ptr_nxt;
    logic [15:0] r_count_hold, w_count_hold_nxt;
    logic        r_count_latched, w_count_latched_nxt;
    logic [7:0]  r_status_hold, w_status_hold_nxt;
    logic        r_status_latched, w_status_latched_nxt;
    logic [7:0]  r_rd_data, w_rd_data_nxt;
    logic        r_rd_ack;

    logic [1:0]  w_rw_eff;
    logic [15:0] w_source;
    logic [7:0]  w_status_byte;

    assign w_rw_eff      = (rw_mode == 2'b00) ? 2'b11 : rw_mode;
    assign w_source      = r_count_latched ? r_count_hold : current_count;
    assign w_status_byte = {out_level, null_count, rw_mode, mode, bcd};

    // NOTE: every next-state signal gets its default first so no path can infer a latch.
    always_comb begin
        w_ptr_nxt            = r_ptr;
        w_count_hold_nxt     = r_count_hold;
        w_count_latched_nxt  = r_count_latched;
        w_status_hold_nxt    = r_status_hold;
        w_status_latched_nxt = r_status_latched;
        w_rd_data_nxt        = r_rd_data;

        if (ctrl_wr) begin
            w_ptr_nxt            = LSB_NEXT;
            w_count_hold_nxt     = 16'h0000;
            w_count_latched_nxt  = 1'b0;
            w_status_hold_nxt    = 8'h00;
            w_status_latched_nxt = 1'b0;
            if (rd) w_rd_data_nxt = 8'h00;
        end else begin
            if (latch_cmd && !r_count_latched) begin
                w_count_hold_nxt    = current_count;
                w_count_latched_nxt = 1'b1;
            end
            if (status_cmd && !r_status_latched) begin
                w_status_hold_nxt    = w_status_byte;
                w_status_latched_nxt = 1'b1;
            end
            if (rd) begin
                if (r_status_latched) begin
                    w_rd_data_nxt        = r_status_hold;
                    w_status_latched_nxt = 1'b0;
                end else begin
                    // A latch can only be released when one was held before this edge,
                    // so a latch_cmd accepted on the same edge is never cancelled.
                    unique case (w_rw_eff)
                        2'b01: begin
                            w_rd_data_nxt = w_source[7:0];
                            w_ptr_nxt     = LSB_NEXT;
                            if (r_count_latched) w_count_latched_nxt = 1'b0;
                        end
                        2'b10: begin
                            w_rd_data_nxt = w_source[15:8];
                            w_ptr_nxt     = LSB_NEXT;
                            if (r_count_latched) w_count_latched_nxt = 1'b0;
                        end
                        default: begin
                            if (r_ptr == LSB_NEXT) begin
                                w_rd_data_nxt = w_source[7:0];
                                w_ptr_nxt     = MSB_NEXT;
                            end else begin
                                w_rd_data_nxt = w_source[15:8];
                                w_ptr_nxt     = LSB_NEXT;
                                if (r_count_latched) w_count_latched_nxt = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr            <= LSB_NEXT;
            r_count_hold     <= 16'h0000;
            r_count_latched  <= 1'b0;
            r_status_hold    <= 8'h00;
            r_status_latched <= 1'b0;
            r_rd_data        <= 8'h00;
            r_rd_ack         <= 1'b0;
        end else begin
            r_ptr            <= w_ptr_nxt;
            r_count_hold     <= w_count_hold_nxt;
            r_count_latched  <= w_count_latched_nxt;
            r_status_hold    <= w_status_hold_nxt;
            r_status_latched <= w_status_latched_nxt;
            r_rd_data        <= w_rd_data_nxt;
            r_rd_ack         <= rd;
        end
    end

    assign rd_data        = r_rd_data;
    assign rd_ack         = r_rd_ack;
    assign count_latched  = r_count_latched;
    assign status_latched = r_status_latched;

endmodule

// File: tb/tb_counter_read_latch.sv
// Directed self-checking bench for counter_read_latch; inputs change 1 ns
// after each rising edge and outputs are sampled at that same point.
module tb_counter_read_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] current_count;
    logic        out_level, null_count, bcd;
    logic [1:0]  rw_mode;
    logic [2:0]  mode;
    logic        ctrl_wr, latch_cmd, status_cmd, rd;
    logic [7:0]  rd_data;
    logic        rd_ack, count_latched, status_latched;

    int checks   = 0;
    int failures = 0;

    counter_read_latch dut (
        .clk            (clk),
        .rst            (rst),
        .current_count  (current_count),
        .out_level      (out_level),
        .null_count     (null_count),
        .rw_mode        (rw_mode),
        .mode           (mode),
        .bcd            (bcd),
        .ctrl_wr        (ctrl_wr),
        .latch_cmd      (latch_cmd),
        .status_cmd     (status_cmd),
        .rd             (rd),
        .rd_data        (rd_data),
        .rd_ack         (rd_ack),
        .count_latched  (count_latched),
        .status_latched (status_latched)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulses; outputs are sampled 1 ns after the edge that took them.
    task automatic pulse(input logic p_ctrl, input logic p_latch, input logic p_status, input logic p_rd);
        ctrl_wr    = p_ctrl;
        latch_cmd  = p_latch;
        status_cmd = p_status;
        rd         = p_rd;
        step();
        ctrl_wr    = 1'b0;
        latch_cmd  = 1'b0;
        status_cmd = 1'b0;
        rd         = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, "_data"}, {8'h00, rd_data}, {8'h00, exp});
        check({tag, "_ack"}, {15'h0, rd_ack}, 16'h0001);
    endtask

    initial begin
        rst = 1'b1;
        current_count = 16'h0000;
        out_level = 1'b0; null_count = 1'b0; bcd = 1'b0;
        rw_mode = 2'b11; mode = 3'b000;
        ctrl_wr = 1'b0; latch_cmd = 1'b0; status_cmd = 1'b0; rd = 1'b0;
        step();
        check("rst_rd_data", {8'h00, rd_data}, 16'h0000);
        check("rst_rd_ack", {15'h0, rd_ack}, 16'h0000);
        check("rst_count_latched", {15'h0, count_latched}, 16'h0000);
        check("rst_status_latched", {15'h0, status_latched}, 16'h0000);
        rst = 1'b0;
        step();

        // Latched 16-bit read in LSB/MSB mode while the live count moves on
        current_count = 16'h1234;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("latch_set", {15'h0, count_latched}, 16'h0001);
        current_count = 16'h1000;
        read_expect("l11_lsb", 8'h34);
        check("l11_kept", {15'h0, count_latched}, 16'h0001);
        read_expect("l11_msb", 8'h12);
        check("l11_clear", {15'h0, count_latched}, 16'h0000);
        step();
        check("ack_drop", {15'h0, rd_ack}, 16'h0000);
        check("data_hold", {8'h00, rd_data}, 16'h0012);

        // Second latch_cmd while held is ignored
        current_count = 16'hABCD;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        current_count = 16'h0001;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        read_expect("relatch_lsb", 8'hCD);
        read_expect("relatch_msb", 8'hAB);

        // Status and count latched together, LSB-only mode
        rw_mode = 2'b01; out_level = 1'b1; null_count = 1'b0; mode = 3'b001; bcd = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'h00FF;
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("both_status", {15'h0, status_latched}, 16'h0001);
        check("both_count", {15'h0, count_latched}, 16'h0001);
        current_count = 16'h3344;
        out_level = 1'b0;
        read_expect("status_byte", 8'h92);
        check("status_clear", {15'h0, status_latched}, 16'h0000);
        check("count_still", {15'h0, count_latched}, 16'h0001);
        read_expect("rw01_lsb", 8'hFF);
        check("rw01_clear", {15'h0, count_latched}, 16'h0000);

        // ctrl_wr restarts the byte pointer; ctrl_wr with rd acks 0x00
        rw_mode = 2'b11;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'h5678;
        read_expect("live_lsb", 8'h78);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'h9ABC;
        read_expect("restart_lsb", 8'hBC);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("cw_rd_data", {8'h00, rd_data}, 16'h0000);
        check("cw_rd_ack", {15'h0, rd_ack}, 16'h0001);
        check("cw_latch_clear", {15'h0, count_latched}, 16'h0000);
        read_expect("cw_after_lsb", 8'hBC);
        read_expect("cw_after_msb", 8'h9A);

        // Asynchronous reset mid-hold in MSB-only mode
        rw_mode = 2'b10;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'h5A5A;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        read_expect("pre_rst", 8'h5A);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        current_count = 16'h7F00;
        #2 rst = 1'b1;
        #1;
        check("async_count_latched", {15'h0, count_latched}, 16'h0000);
        check("async_rd_data", {8'h00, rd_data}, 16'h0000);
        step();
        rst = 1'b0;
        read_expect("post_rst_msb", 8'h7F);

        // rd with latch_cmd on the final MSB of a held latch
        rw_mode = 2'b11;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'h1111;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        read_expect("fin_lsb", 8'h11);
        current_count = 16'h2222;
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check("fin_msb", {8'h00, rd_data}, 16'h0011);
        check("fin_clear", {15'h0, count_latched}, 16'h0000);
        read_expect("fin_live", 8'h22);

        // rw_mode 00 behaves as 11; rd with status_cmd is served from the count path
        rw_mode = 2'b00; out_level = 1'b0; null_count = 1'b1; mode = 3'b101; bcd = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        current_count = 16'hC3A5;
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("rs_count_path", {8'h00, rd_data}, 16'h00A5);
        check("rs_status_set", {15'h0, status_latched}, 16'h0001);
        read_expect("rs_status", 8'h4B);
        read_expect("rs_msb", 8'hC3);

        // Back-to-back reads every cycle
        current_count = 16'h0F1E;
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b2b_data%0d", i), {8'h00, rd_data}, (i % 2 == 0) ? 16'h001E : 16'h000F);
            check($sformatf("b2b_ack%0d", i), {15'h0, rd_ack}, 16'h0001);
        end
        rd = 1'b0;

        // rd with latch_cmd while unlatched: read is live, latch is taken
        current_count = 16'h4455;
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check("rl_live", {8'h00, rd_data}, 16'h0055);
        check("rl_set", {15'h0, count_latched}, 16'h0001);
        current_count = 16'h6677;
        read_expect("rl_held_msb", 8'h44);
        check("rl_clear", {15'h0, count_latched}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
